// File: rtl/mul4x4_share_arbiter.sv
// Round-robin owner of the shared 4x4 matrix multiplier in the ZF detector:
// grants one requester, runs the multiplier handshake, returns the product.
module mul4x4_share_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [256*NUM_REQ-1:0] a_in,
    input  logic [256*NUM_REQ-1:0] b_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [255:0]           result,
    output logic                   err_timeout,
    output logic                   mul_enable,
    output logic                   mul_accept_in,
    output logic [255:0]           mul_A,
    output logic [255:0]           mul_B,
    input  logic                   mul_idle,
    input  logic                   mul_ready,
    input  logic [255:0]           mul_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [WD_W-1:0]    wdog;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_hit;
    logic [NUM_REQ-1:0] pick_oh;
    logic [255:0]       sel_a;
    logic [255:0]       sel_b;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % NUM_REQ);
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        pick_idx = ptr;
        pick_hit = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_hit && req[wrap_idx(32'(ptr) + 32'(k))]) begin
                pick_idx = wrap_idx(32'(ptr) + 32'(k));
                pick_hit = 1'b1;
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_oh[i] = 1'b1;
                sel_a      = a_in[i*256 +: 256];
                sel_b      = b_in[i*256 +: 256];
            end
        end
    end

    assign mul_enable    = (state == ST_ISSUE);
    assign mul_accept_in = (state == ST_WAIT) && mul_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ptr         <= PTR_RST;
            wdog        <= '0;
            gnt         <= '0;
            done        <= '0;
            result      <= '0;
            err_timeout <= 1'b0;
            mul_A       <= '0;
            mul_B       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        ptr   <= pick_idx;
                        gnt   <= pick_oh;
                        mul_A <= sel_a;
                        mul_B <= sel_b;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mul_idle) begin
                        wdog  <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A ready arriving on the last watchdog cycle still counts as success.
                    if (mul_ready) begin
                        result <= mul_result;
                        done   <= gnt;
                        state  <= ST_DONE;
                    end else if (wdog == WD_LAST) begin
                        err_timeout <= 1'b1;
                        done        <= gnt;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul4x4_share_arbiter.sv
// Bench for mul4x4_share_arbiter: stub multiplier, transaction-level scoreboard,
// directed timing scenarios and a randomized requester phase.
module tb_mul4x4_share_arbiter;

    localparam int NUM_REQ = 3;
    localparam int TIMEOUT = 8;
    localparam logic [255:0] RES1 =
        256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;

    logic                   clk;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req;
    logic [256*NUM_REQ-1:0] a_in;
    logic [256*NUM_REQ-1:0] b_in;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     done;
    logic [255:0]           result;
    logic                   err_timeout;
    logic                   mul_enable;
    logic                   mul_accept_in;
    logic [255:0]           mul_A;
    logic [255:0]           mul_B;
    logic                   mul_idle;
    logic                   mul_ready;
    logic [255:0]           mul_result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int exp_lat     = 5;
    bit chk_res     = 1'b1;
    bit idle_block  = 1'b0;
    bit never_ready = 1'b0;
    int extra_lat   = 0;

    mul4x4_share_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .gnt          (gnt),
        .done         (done),
        .result       (result),
        .err_timeout  (err_timeout),
        .mul_enable   (mul_enable),
        .mul_accept_in(mul_accept_in),
        .mul_A        (mul_A),
        .mul_B        (mul_B),
        .mul_idle     (mul_idle),
        .mul_ready    (mul_ready),
        .mul_result   (mul_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "bench timeout");
    end

    // Multiplier stub: IDLE -> MUL, ADD, END_ADD (plus extra_lat) -> READY until accepted.
    logic         s_idle;
    logic         s_rdy;
    int           s_cnt;
    logic [255:0] lat_a;
    logic [255:0] lat_b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_idle <= 1'b1;
            s_rdy  <= 1'b0;
            s_cnt  <= 0;
            lat_a  <= '0;
            lat_b  <= '0;
        end else if (s_idle) begin
            if (mul_enable && mul_idle) begin
                s_idle <= 1'b0;
                s_cnt  <= 3 + extra_lat;
            end
        end else if (!s_rdy) begin
            if (s_cnt == 3 + extra_lat) begin
                lat_a <= mul_A;
                lat_b <= mul_B;
            end
            if (s_cnt == 1) s_rdy <= 1'b1;
            s_cnt <= s_cnt - 1;
        end else if (mul_accept_in) begin
            s_rdy  <= 1'b0;
            s_idle <= 1'b1;
        end
    end

    assign mul_idle   = s_idle && !idle_block;
    assign mul_ready  = s_rdy && !never_ready;
    assign mul_result = lat_a + lat_b;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, wanted %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int w);
        logic [NUM_REQ-1:0] v = '0;
        if (w >= 0 && w < NUM_REQ) v[w] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first requesting index after the last winner, with wrap.
    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    // Scoreboard: predicts each winner and the product it must receive.
    int                     model_ptr = NUM_REQ - 1;
    logic [NUM_REQ-1:0]     prev_req  = '0;
    logic [NUM_REQ-1:0]     prev_gnt  = '0;
    logic [256*NUM_REQ-1:0] prev_a    = '0;
    logic [256*NUM_REQ-1:0] prev_b    = '0;
    logic [255:0]           cap_a     = '0;
    logic [255:0]           cap_b     = '0;
    int                     win       = -1;
    int                     grant_cyc = 0;
    bit                     inflight  = 1'b0;
    int                     grant_log[$];
    int                     n_grant   = 0;
    int                     n_done    = 0;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            model_ptr = NUM_REQ - 1;
            prev_gnt  = '0;
            inflight  = 1'b0;
        end else begin
            if (gnt != '0 && prev_gnt == '0) begin
                win = rr_pick(model_ptr, prev_req);
                check("mon_grant", gnt, onehot(win));
                if (win >= 0) begin
                    cap_a = prev_a[win*256 +: 256];
                    cap_b = prev_b[win*256 +: 256];
                    check("mon_mul_a", mul_A, cap_a);
                    check("mon_mul_b", mul_B, cap_b);
                    model_ptr = win;
                end
                grant_cyc = cyc;
                inflight  = 1'b1;
                grant_log.push_back(win);
                n_grant++;
            end
            if (done != '0) begin
                check("mon_done_inflight", inflight, 1'b1);
                check("mon_done_owner", done, onehot(win));
                check("mon_latency", cyc - grant_cyc, exp_lat);
                check("mon_mul_a_hold", mul_A, cap_a);
                if (chk_res) check("mon_result", result, cap_a + cap_b);
                inflight = 1'b0;
                n_done++;
            end
            prev_gnt = gnt;
        end
        prev_req = req;
        prev_a   = a_in;
        prev_b   = b_in;
    end

    task automatic do_reset();
        reset_n     = 1'b0;
        req         = '0;
        idle_block  = 1'b0;
        never_ready = 1'b0;
        extra_lat   = 0;
        exp_lat     = 5;
        chk_res     = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_gnt"}, gnt, '0);
        check({pfx, "_done"}, done, '0);
        check({pfx, "_result"}, result, '0);
        check({pfx, "_err"}, err_timeout, 1'b0);
        check({pfx, "_en"}, mul_enable, 1'b0);
        check({pfx, "_acc"}, mul_accept_in, 1'b0);
        check({pfx, "_mul_a"}, mul_A, '0);
        check({pfx, "_mul_b"}, mul_B, '0);
    endtask

    initial begin
        logic [255:0]       opa [NUM_REQ];
        logic [255:0]       opb [NUM_REQ];
        logic [NUM_REQ-1:0] d;
        int                 dcyc[$];
        int                 dval[$];
        int                 guard;
        int                 base;
        int                 slot;
        int                 g0;
        int                 d0;

        reset_n = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        #3;
        check_all_zero("reset");
        do_reset();

        // Single request, idle multiplier: exact cycle-by-cycle timing.
        do_reset();
        a_in[0 +: 256] = RES1;
        b_in[0 +: 256] = '0;
        req = 3'b001;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("t1_gnt_c%0d", c), gnt, (c >= 1 && c <= 6) ? 3'b001 : 3'b000);
            check($sformatf("t1_en_c%0d", c), mul_enable, c == 1);
            check($sformatf("t1_acc_c%0d", c), mul_accept_in, c == 5);
            check($sformatf("t1_done_c%0d", c), done, (c == 6) ? 3'b001 : 3'b000);
            if (c >= 6) check($sformatf("t1_result_c%0d", c), result, RES1);
            @(posedge clk);
            #1;
            req = '0;
        end

        // All three requesting: order 0,1,2 with 7-cycle spacing.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = rand256();
            opb[i] = rand256();
            a_in[i*256 +: 256] = opa[i];
            b_in[i*256 +: 256] = opb[i];
        end
        req = 3'b111;
        dcyc.delete();
        dval.delete();
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            d = done;
            if (done != '0) begin
                dcyc.push_back(c);
                dval.push_back(int'(done));
            end
            if (c == 1 || c == 8 || c == 15) check($sformatf("t2_mul_a_c%0d", c), mul_A, opa[(c - 1) / 7]);
            @(posedge clk);
            #1;
            req = req & ~d;
        end
        check("t2_done_count", dcyc.size(), 3);
        for (int k = 0; k < 3 && k < dcyc.size(); k++) begin
            check($sformatf("t2_done_cycle%0d", k), dcyc[k], 6 + 7 * k);
            check($sformatf("t2_done_owner%0d", k), dval[k], 1 << k);
        end

        // Requesters 0 and 2 always requesting, then requester 1 joins.
        do_reset();
        grant_log.delete();
        req = 3'b101;
        guard = 0;
        while (grant_log.size() < 4 && guard < 80) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("t3_four_grants_in_time", guard < 80, 1'b1);
        for (int k = 0; k < 4; k++)
            check($sformatf("t3_order%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, (k % 2 == 0) ? 0 : 2);
        req[1] = 1'b1;
        base  = grant_log.size();
        slot  = -1;
        guard = 0;
        while (slot < 0 && guard < 80) begin
            @(posedge clk);
            #1;
            guard++;
            for (int k = base; k < grant_log.size(); k++)
                if (grant_log[k] == 1 && slot < 0) slot = k - base + 1;
        end
        check("t3_req1_within_two_slots", slot >= 1 && slot <= 2, 1'b1);

        // Multiplier busy for 3 cycles after ISSUE.
        do_reset();
        a_in[0 +: 256] = rand256();
        b_in[0 +: 256] = rand256();
        exp_lat    = 8;
        idle_block = 1'b1;
        req = 3'b001;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            d = done;
            check($sformatf("t4_en_c%0d", c), mul_enable, c >= 1 && c <= 4);
            check($sformatf("t4_done_c%0d", c), done, (c == 9) ? 3'b001 : 3'b000);
            @(posedge clk);
            #1;
            req = req & ~d;
            if (c == 3) idle_block = 1'b0;
        end

        // Ready arrives on the final watchdog cycle: success, no error.
        do_reset();
        opa[0] = rand256();
        opb[0] = rand256();
        a_in[0 +: 256] = opa[0];
        b_in[0 +: 256] = opb[0];
        extra_lat = 4;
        exp_lat   = 9;
        req = 3'b001;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            d = done;
            check($sformatf("t5a_done_c%0d", c), done, (c == 10) ? 3'b001 : 3'b000);
            check($sformatf("t5a_err_c%0d", c), err_timeout, 1'b0);
            check($sformatf("t5a_acc_c%0d", c), mul_accept_in, c == 9);
            if (c == 10) check("t5a_result", result, opa[0] + opb[0]);
            @(posedge clk);
            #1;
            req = req & ~d;
        end

        // Multiplier never ready: watchdog abort, sticky error, result untouched.
        do_reset();
        a_in[0 +: 256] = rand256();
        b_in[0 +: 256] = rand256();
        never_ready = 1'b1;
        exp_lat     = 9;
        chk_res     = 1'b0;
        req = 3'b001;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            d = done;
            check($sformatf("t5_done_c%0d", c), done, (c == 10) ? 3'b001 : 3'b000);
            check($sformatf("t5_err_c%0d", c), err_timeout, c >= 10);
            check($sformatf("t5_acc_c%0d", c), mul_accept_in, 1'b0);
            if (c >= 10) check($sformatf("t5_result_c%0d", c), result, '0);
            @(posedge clk);
            #1;
            req = req & ~d;
        end
        do_reset();
        check("t5_err_cleared_by_reset", err_timeout, 1'b0);

        // Reset pulse while requester 1 is in WAIT, then a fresh 3'b110 request.
        do_reset();
        a_in[256 +: 256] = rand256();
        b_in[256 +: 256] = rand256();
        req = 3'b010;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t6_gnt_before_reset", gnt, 3'b010);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req = 3'b110;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            d = done;
            check($sformatf("t6_gnt_c%0d", c), gnt, (c >= 1 && c <= 6) ? 3'b010 : 3'b000);
            check($sformatf("t6_done_c%0d", c), done, (c == 6) ? 3'b010 : 3'b000);
            @(posedge clk);
            #1;
            req = req & ~d;
        end

        // Randomized requesters obeying the hold-until-done contract.
        do_reset();
        g0 = n_grant;
        d0 = n_done;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            d = done;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (d[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    a_in[i*256 +: 256] = rand256();
                    b_in[i*256 +: 256] = rand256();
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
                end else if (!gnt[i] && $urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end else if (gnt[i] && $urandom_range(0, 3) == 0) begin
                    a_in[i*256 +: 256] = rand256();
                    b_in[i*256 +: 256] = rand256();
                end
            end
        end
        req = '0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("rand_every_grant_completed", n_done - d0, n_grant - g0);
        check("rand_enough_traffic", (n_done - d0) > 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul4x4_share_arbiter.md
Name: mul4x4_share_arbiter

Overview:
- Round-robin scheduler that shares one 4x4 x 4x4 fixed-point matrix multiplier among NUM_REQ requesters in the ZF detector.
- Typical requesters: Gram-matrix stage, inverse-product stage, equalizer stage.
- Latches the winning requester's operands and drives the multiplier's enable/accept handshake.
- Captures the 256-bit product and returns it to the winner with a one-cycle done pulse.
- Also provides a watchdog for a stalled multiplier.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT, 32, max cycles in WAIT for mul_ready before abort.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- a_in  in  256*NUM_REQ  operand A; requester i occupies bits [256*i+255:256*i].
- b_in  in  256*NUM_REQ  operand B, same packing as a_in.
- gnt  out  NUM_REQ  one-hot, owner of the multiplier.
- done  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- result  out  256  registered product for the done requester.
- err_timeout  out  1  sticky watchdog flag.
- mul_enable  out  1  to multiplier enable.
- mul_accept_in  out  1  to multiplier accept_in (releases its READY state).
- mul_A  out  256  registered operand A.
- mul_B  out  256  registered operand B.
- mul_idle  in  1  from multiplier accept_out (high in its IDLE).
- mul_ready  in  1  from multiplier ready_out.
- mul_result  in  256  multiplier result.

Behaviour:
- Reset is asynchronous, active-low (reset_n), clock is clk.
- Reset values: state=IDLE, gnt=0, done=0, result=0, err_timeout=0, mul_enable=0, mul_accept_in=0, mul_A=0, mul_B=0, rr pointer=NUM_REQ-1, watchdog=0.
- Reset mid-operation aborts immediately. No done pulse is issued. The multiplier shares reset_n.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req!=0, pick the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Latch idx, set ptr=idx, load mul_A/mul_B from that requester's slice, set gnt[idx]. Go to ISSUE.
  - If req==0, stay in IDLE.
- ISSUE:
  - mul_enable=1 (combinational from state).
  - If mul_idle=1, go to WAIT and clear the watchdog. Otherwise stay, holding enable.
  - There is no timeout in ISSUE.
- WAIT:
  - Watchdog increments each cycle.
  - If mul_ready=1: mul_accept_in=1 this cycle, result<=mul_result, go to DONE.
  - Else if watchdog==TIMEOUT-1: err_timeout<=1, result unchanged, go to DONE.
  - If both occur in the same cycle, mul_ready wins and err is not set.
- DONE:
  - done[idx]=1 for exactly one cycle. gnt[idx] stays high through DONE.
  - Next state is IDLE, gnt cleared.
- Requester contract:
  - Hold req and the operands until done is seen.
  - Drop req on the edge that samples done.
  - If req is still high in the following IDLE cycle, it is a new request.
  - a_in/b_in are sampled only in the IDLE grant cycle; later changes are ignored.
- mul_A/mul_B stay stable from ISSUE through DONE. This is required because the multiplier samples its operands in its MUL cycle.
- Latency with an idle multiplier, req sampled in cycle 0:
  - gnt and mul_enable in cycle 1.
  - Multiplier MUL/ADD/END_ADD in cycles 2-4.
  - mul_ready and mul_accept_in in cycle 5.
  - done and result valid in cycle 6.
  - Next grant at the earliest in cycle 7, giving 7-cycle issue spacing.
- A requester whose req drops before it is granted is simply skipped.
- The pointer advances only on grant.
- gnt and done are never asserted for more than one requester.
- err_timeout clears only on reset.

Test Plan:
1. Stub multiplier (idle, 4-cycle pipeline, mul_result=256'h0001_0002_..._0010). Pulse req=3'b001 at cycle 0 → gnt=001 cycles 1-6, mul_enable cycle 1, mul_accept_in cycle 5, done=001 cycle 6, result=256'h0001_..._0010.
2. req=3'b111 held, each requester dropping after its done → grant order 0,1,2, done pulses at cycles 6,13,20, mul_A matches each slice.
3. req0 and req2 continuously re-requesting → alternating grants 0,2,0,2; req1 never starved once asserted (granted within 2 slots).
4. mul_idle held low for 3 cycles after ISSUE → mul_enable stays high 4 cycles; WAIT entered when mul_idle=1; done shifts by 3 cycles.
5. Stub never asserts mul_ready, TIMEOUT=8 → done after 8 WAIT cycles, err_timeout=1 sticky, result unchanged (0).
6. reset_n pulsed low in WAIT → all outputs 0 asynchronously, ptr=NUM_REQ-1; after release a fresh req=3'b110 grants requester 1 first.
